// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for hazard_scoreboard.
// master: decode stage (drives instruction fields and flush).
// slave:  scoreboard (drives stall/issue/forwarding/status).
`ifndef REG_SIZE
`define REG_SIZE 2
`endif
`ifndef REG_NUMS
`define REG_NUMS 4
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

interface hazard_scoreboard_if;
    logic                  id_valid;
    logic [`REG_SIZE-1:0]  id_rs1;
    logic [`REG_SIZE-1:0]  id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [`REG_SIZE-1:0]  id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  flush;

    logic                  stall;
    logic                  issue;
    logic [`REG_NUMS-1:0]  pending_mask;
    logic [1:0]            fwd_sel1;
    logic [1:0]            fwd_sel2;
    logic [`WORD_SIZE-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_reg_write, id_is_load, flush,
        input  stall, issue, pending_mask, fwd_sel1, fwd_sel2, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_reg_write, id_is_load, flush,
        output stall, issue, pending_mask, fwd_sel1, fwd_sel2, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destination registers in the EX/MEM/WB slots and decides
// stall, issue and operand source for the instruction in decode.
// Build option: define HAZARD_FORWARDING_EN to enable EX/MEM/WB forwarding (load-use
// stalls only). Without it, any EX/MEM dependency stalls and fwd_sel is tied to 0.
`ifndef REG_SIZE
`define REG_SIZE 2
`endif
`ifndef REG_NUMS
`define REG_NUMS 4
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module hazard_scoreboard (
    input  logic               Clk,
    input  logic               Reset,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned RegSize  = `REG_SIZE;
    localparam int unsigned RegNums  = `REG_NUMS;
    localparam int unsigned WordSize = `WORD_SIZE;

    typedef logic [RegSize-1:0]  reg_t;
    typedef logic [WordSize-1:0] cnt_t;

    typedef struct packed {
        logic v;
        reg_t rd;
        logic ld;
    } slot_t;

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;
    slot_t wb_q, wb_d;
    cnt_t  stall_count_q, stall_count_d;

    logic m1_ex, m1_mem, m2_ex, m2_mem;
`ifdef HAZARD_FORWARDING_EN
    logic m1_wb, m2_wb;
`endif
    logic               hazard;
    logic               stall;
    logic               issue;
    logic [1:0]         fwd_sel1;
    logic [1:0]         fwd_sel2;
    logic [RegNums-1:0] pending_mask;

    // WB retires without being read in the stall-only build; ld only matters in EX.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{wb_q, ex_q.ld, mem_q.ld};

    function automatic logic src_match(input logic valid, input logic used,
                                       input reg_t rs, input slot_t s);
        return valid & used & s.v & (s.rd == rs);
    endfunction

    // Compare each used source against every tracked slot.
    always_comb begin
        m1_ex  = src_match(bus.id_valid, bus.id_rs1_used, bus.id_rs1, ex_q);
        m1_mem = src_match(bus.id_valid, bus.id_rs1_used, bus.id_rs1, mem_q);
        m2_ex  = src_match(bus.id_valid, bus.id_rs2_used, bus.id_rs2, ex_q);
        m2_mem = src_match(bus.id_valid, bus.id_rs2_used, bus.id_rs2, mem_q);
`ifdef HAZARD_FORWARDING_EN
        m1_wb  = src_match(bus.id_valid, bus.id_rs1_used, bus.id_rs1, wb_q);
        m2_wb  = src_match(bus.id_valid, bus.id_rs2_used, bus.id_rs2, wb_q);
`endif
    end

    // Hazard, stall/issue decision and operand source selection.
    always_comb begin
        hazard   = 1'b0;
        fwd_sel1 = 2'd0;
        fwd_sel2 = 2'd0;
`ifdef HAZARD_FORWARDING_EN
        // Only a load in EX cannot be bypassed; youngest matching slot wins.
        hazard = (m1_ex | m2_ex) & ex_q.ld;
        if (m1_ex)       fwd_sel1 = 2'd1;
        else if (m1_mem) fwd_sel1 = 2'd2;
        else if (m1_wb)  fwd_sel1 = 2'd3;
        if (m2_ex)       fwd_sel2 = 2'd1;
        else if (m2_mem) fwd_sel2 = 2'd2;
        else if (m2_wb)  fwd_sel2 = 2'd3;
`else
        // WB is readable through the negedge register-file write, so never stalls.
        hazard = m1_ex | m1_mem | m2_ex | m2_mem;
`endif
        // Reset and flush both suppress stall and issue.
        stall = hazard & ~bus.flush & ~Reset;
        issue = bus.id_valid & ~stall & ~bus.flush & ~Reset;
    end

    // One pending bit per register with a valid write in EX or MEM.
    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < RegNums; r++) begin
            if ((ex_q.v && ex_q.rd == reg_t'(r)) || (mem_q.v && mem_q.rd == reg_t'(r))) begin
                pending_mask[r] = 1'b1;
            end
        end
    end

    // Slot shift, EX fill on issue, saturating stall counter.
    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d = '{v: bus.id_reg_write, rd: bus.id_rd, ld: bus.id_is_load};
        end
        mem_d = ex_q;
        wb_d  = mem_q;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + cnt_t'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.issue        = issue;
    assign bus.pending_mask = pending_mask;
    assign bus.fwd_sel1     = fwd_sel1;
    assign bus.fwd_sel2     = fwd_sel2;
    assign bus.stall_count  = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow the selected build
// (HAZARD_FORWARDING_EN defined or not).
module tb_hazard_scoreboard;
    logic        Clk;
    logic        Reset;
    int unsigned n_checks;
    int unsigned n_pass;
    logic [15:0] exp_cnt;

    hazard_scoreboard_if bus ();

    hazard_scoreboard dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rs1, input logic u1, input logic [1:0] rs2,
                         input logic u2, input logic [1:0] rd, input logic wr,
                         input logic ld);
        bus.id_valid     = 1'b1;
        bus.id_rs1       = rs1;
        bus.id_rs1_used  = u1;
        bus.id_rs2       = rs2;
        bus.id_rs2_used  = u2;
        bus.id_rd        = rd;
        bus.id_reg_write = wr;
        bus.id_is_load   = ld;
        bus.flush        = 1'b0;
    endtask

    task automatic idle();
        drive(2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
    endtask

    // Inputs change and outputs are sampled 2-3 time units after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_cnt  = 16'd0;

        // Reset held two cycles with a valid writing instruction in decode.
        Reset = 1'b1;
        drive(2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0);
        tick();
        check("rst_c1_stall", bus.stall, 1'b0);
        check("rst_c1_issue", bus.issue, 1'b0);
        tick();
        check("rst_c2_stall", bus.stall, 1'b0);
        check("rst_c2_issue", bus.issue, 1'b0);
        check("rst_count", bus.stall_count, 16'd0);
        check("rst_pending", bus.pending_mask, 4'b0000);
        Reset = 1'b0;
        idle();
        settle();
        check("post_rst_pending", bus.pending_mask, 4'b0000);
        check("post_rst_fwd1", bus.fwd_sel1, 2'd0);
        check("post_rst_fwd2", bus.fwd_sel2, 2'd0);
        check("post_rst_issue", bus.issue, 1'b0);

        // RAW on rs1 after a plain write to r2.
        drive(2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0);
        settle();
        check("raw_producer_issue", bus.issue, 1'b1);
        tick();
        drive(2'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        settle();
`ifdef HAZARD_FORWARDING_EN
        check("raw_ex_stall", bus.stall, 1'b0);
        check("raw_ex_issue", bus.issue, 1'b1);
        check("raw_ex_fwd1", bus.fwd_sel1, 2'd1);
`else
        check("raw_c1_stall", bus.stall, 1'b1);
        check("raw_c1_issue", bus.issue, 1'b0);
        check("raw_c1_pending", bus.pending_mask, 4'b0100);
        tick();
        settle();
        check("raw_c2_stall", bus.stall, 1'b1);
        check("raw_c2_pending", bus.pending_mask, 4'b0100);
        tick();
        settle();
        check("raw_c3_stall", bus.stall, 1'b0);
        check("raw_c3_issue", bus.issue, 1'b1);
        check("raw_c3_fwd1", bus.fwd_sel1, 2'd0);
        exp_cnt = exp_cnt + 16'd2;
`endif
        tick();
        idle();
        settle();
        check("raw_count", bus.stall_count, exp_cnt);

        // Load to r1 followed by a consumer on rs2.
        drive(2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1);
        settle();
        check("ldu_load_issue", bus.issue, 1'b1);
        tick();
        drive(2'd0, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0);
        settle();
        check("ldu_c1_stall", bus.stall, 1'b1);
        check("ldu_c1_issue", bus.issue, 1'b0);
        tick();
        settle();
`ifdef HAZARD_FORWARDING_EN
        check("ldu_c2_stall", bus.stall, 1'b0);
        check("ldu_c2_issue", bus.issue, 1'b1);
        check("ldu_c2_fwd2", bus.fwd_sel2, 2'd2);
        exp_cnt = exp_cnt + 16'd1;
`else
        check("ldu_c2_stall", bus.stall, 1'b1);
        tick();
        settle();
        check("ldu_c3_stall", bus.stall, 1'b0);
        check("ldu_c3_issue", bus.issue, 1'b1);
        check("ldu_c3_fwd2", bus.fwd_sel2, 2'd0);
        exp_cnt = exp_cnt + 16'd2;
`endif
        tick();
        idle();
        settle();
        check("ldu_count", bus.stall_count, exp_cnt);

        // Write r3, two independent writes, then a WB-only dependency on r3.
        drive(2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1, 1'b0);
        tick();
        drive(2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0);
        tick();
        drive(2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        drive(2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        settle();
        check("wb_unused_fwd1", bus.fwd_sel1, 2'd0);
        check("wb_pending", bus.pending_mask, 4'b0011);
        bus.id_rs1_used = 1'b1;
        settle();
        check("wb_stall", bus.stall, 1'b0);
        check("wb_issue", bus.issue, 1'b1);
`ifdef HAZARD_FORWARDING_EN
        check("wb_fwd1", bus.fwd_sel1, 2'd3);
`else
        check("wb_fwd1", bus.fwd_sel1, 2'd0);
`endif
        bus.id_valid = 1'b0;
        settle();
        check("wb_novalid_fwd1", bus.fwd_sel1, 2'd0);
        check("wb_novalid_issue", bus.issue, 1'b0);
        tick();
        tick();
        tick();

        // Load-use hazard coinciding with a flush.
        drive(2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b1);
        tick();
        drive(2'd2, 1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0);
        bus.flush = 1'b1;
        settle();
        check("flush_stall", bus.stall, 1'b0);
        check("flush_issue", bus.issue, 1'b0);
        check("flush_pending", bus.pending_mask, 4'b0100);
        tick();
        idle();
        settle();
        check("flush_after_pending", bus.pending_mask, 4'b0100);
        check("flush_count", bus.stall_count, exp_cnt);
        tick();
        settle();
        check("flush_drain_pending", bus.pending_mask, 4'b0000);
        tick();

        // Back-to-back load-use chain on r2; counter preloaded near the top.
        drive(2'd2, 1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 4 && bus.stall !== 1'b1; i++) tick();
        check("sat_chain_stall", bus.stall, 1'b1);
        force dut.stall_count_q = 16'hFFF0;
        tick();
        release dut.stall_count_q;
        for (int i = 0; i < 60; i++) tick();
        check("sat_count", bus.stall_count, 16'hFFFF);
        for (int i = 0; i < 4 && bus.stall !== 1'b1; i++) tick();
        check("sat_hold_stall", bus.stall, 1'b1);
        check("sat_hold_count", bus.stall_count, 16'hFFFF);

        // Reset in the middle of a stall drops all in-flight slots.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        settle();
        check("midrst_stall", bus.stall, 1'b0);
        check("midrst_issue", bus.issue, 1'b1);
        check("midrst_count", bus.stall_count, 16'd0);
        check("midrst_pending", bus.pending_mask, 4'b0000);
        tick();
        settle();
        check("midrst_next_stall", bus.stall, 1'b1);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL: Clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL: Reset  in  1  reset, synchronous and active-high.
REQ-003 SHALL: id_valid  in  1  decode stage holds a valid instruction.
REQ-004 SHALL: id_rs1, id_rs2  in  `REG_SIZE each  source register addresses; these same addresses drive the register file read ports.
REQ-005 SHALL: id_rs1_used, id_rs2_used  in  1 each  the instruction reads that source.
REQ-006 SHALL: id_rd  in  `REG_SIZE; id_reg_write  in  1; id_is_load  in  1  destination register, write flag and load flag.
REQ-007 SHALL: flush  in  1  squash the decode instruction this cycle (taken branch or jump).
REQ-008 SHALL: stall  out  1  hold the PC and IF/ID latch this cycle.
REQ-009 SHALL: issue  out  1  the instruction advances to EX this cycle.
REQ-010 SHALL: pending_mask  out  `REG_NUMS  bit r set when register r has a valid write in the EX or MEM slot.
REQ-011 SHALL: fwd_sel1, fwd_sel2  out  2 each  operand source: 0 = register file, 1 = EX, 2 = MEM, 3 = WB.
REQ-012 SHALL: stall_count  out  `WORD_SIZE  saturating count of stall cycles.

Function
REQ-013 SHALL: keep three slots EX, MEM and WB, each holding {v, rd, ld}; every posedge shifts WB<-MEM, MEM<-EX, and the old WB contents retire.
REQ-014 SHALL: load the EX slot on issue with {id_reg_write, id_rd, id_is_load}; otherwise load it with a bubble (v=0).
REQ-015 SHALL: match(s, slot) is true when id_valid, id_s_used, slot.v and slot.rd==id_s all hold.
REQ-016 SHALL: never stall on a WB-slot match, because the register file writes on negedge, so the value is readable within the same cycle.
REQ-017 SHALL: issue = id_valid & ~stall & ~flush; stall = hazard & ~flush, so flush wins over stall.
REQ-018 SHALL: on flush, load the EX slot with a bubble; slots already in EX, MEM and WB are not affected.
REQ-019 SHALL: compute stall, issue, pending_mask and fwd_sel combinationally from the current slots and inputs, with zero latency.
REQ-020 SHALL: increment stall_count by 1 on each posedge where stall=1, holding at 16'hFFFF with no wrap-around.
REQ-021 SHALL: with id_valid=0, drive stall=0, issue=0 and fwd_sel=0, while the slots still shift.
REQ-022 SHALL: always set fwd_sel to 0 for a source whose used flag is 0.

Reset
REQ-023 SHALL: on a posedge with Reset=1, clear all slot v, rd and ld bits and clear stall_count to 0; Reset overrides issue and flush.
REQ-024 SHALL: drive stall=0, issue=0, pending_mask=0 and fwd_sel1=fwd_sel2=0 during and after reset until the first valid issue, given id_valid=0.
REQ-025 SHALL: have Reset asserted mid-stall discard all in-flight slots, with no stall on the first cycle after reset.

Configuration
REQ-026 SHALL: compile forwarding in when macro HAZARD_FORWARDING_EN is defined.
REQ-027 SHALL: when HAZARD_FORWARDING_EN is defined, set hazard = any used source matching the EX slot with ld=1 (load-use only); fwd_sel picks the youngest matching slot, EX then MEM then WB, and 0 if there is no match.
REQ-028 SHALL: when HAZARD_FORWARDING_EN is not defined, set hazard = any used source matching the EX or MEM slot, and tie fwd_sel1 and fwd_sel2 to 0.

Verification
REQ-029 SHALL: Reset=1 for 2 cycles with id_valid=1 -> stall=0, issue=0, stall_count=0, pending_mask=4'b0000.
REQ-030 SHALL: issue rd=2 (write), then next instruction rs1=2 -> without forwarding, stall=1 for 2 cycles, issue on the 3rd, stall_count=2; with forwarding, no stall and fwd_sel1=1.
REQ-031 SHALL: issue a load to rd=1, then rs2=1 -> with forwarding, stall=1 for exactly 1 cycle, then issue with fwd_sel2=2 (MEM).
REQ-032 SHALL: rd=3 written, two independent instructions, then rs1=3 -> WB match only; stall=0 in both builds, fwd_sel1=3 with forwarding.
REQ-033 SHALL: hazard present with flush=1 in the same cycle -> stall=0, issue=0, EX slot bubble, pending_mask reflects only the older slots.
REQ-034 SHALL: hold a hazard for more than 65535 cycles by keeping the source slot refilled -> stall_count saturates at 16'hFFFF; Reset returns it to 0.
